// File: rtl/lsu_initiator.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// One request is in flight at a time. Accesses that straddle a word boundary
// become two back-to-back word transactions, or an error response when
// misaligned accesses are disabled. Every output is driven from a flop.

module lsu_initiator #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    // Access size in bytes: B/BU = 1, H/HU = 2, W = 4.
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        logic [2:0] n;
        case (f3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Encodings with no meaning; unsigned variants have no meaning for stores.
    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = we;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // True when the access runs past the end of its first word.
    function automatic logic is_split(input logic [1:0] o, input logic [2:0] f3);
        return ({2'b00, o} + {1'b0, size_bytes(f3)}) > 4'd4;
    endfunction

    // Byte-lane mask spanning two words: low nibble for word 0, high for word 1.
    function automatic logic [7:0] byte_mask(input logic [1:0] o, input logic [2:0] f3);
        logic [7:0] base;
        case (f3[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << o;
    endfunction

    // Store data trimmed to the access size and shifted onto its byte lanes.
    function automatic logic [63:0] lane_data(input logic [1:0] o, input logic [2:0] f3,
                                              input logic [31:0] wd);
        logic [31:0] keep;
        case (f3[1:0])
            2'b00:   keep = 32'h0000_00FF;
            2'b01:   keep = 32'h0000_FFFF;
            default: keep = 32'hFFFF_FFFF;
        endcase
        return {32'h0000_0000, wd & keep} << {o, 3'b000};
    endfunction

    // Right-align returned bytes and sign- or zero-extend them.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                                input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] d;
        logic [31:0] r;
        d = {hi, lo} >> {o, 3'b000};
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b010:  r = d[31:0];
            3'b100:  r = {24'h00_0000, d[7:0]};
            3'b101:  r = {16'h0000, d[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [7:0]  in_mask_s, cap_mask_s;
    logic [63:0] in_lane_s, cap_lane_s;

    assign in_mask_s  = byte_mask(req_addr[1:0], req_funct3);
    assign in_lane_s  = lane_data(req_addr[1:0], req_funct3, req_wdata);
    assign cap_mask_s = byte_mask(addr_q[1:0], f3_q);
    assign cap_lane_s = lane_data(addr_q[1:0], f3_q, wdata_q);

    // Next-state, request capture and next values of every registered output.
    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        f3_d            = f3_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        lo_d            = lo_q;
        resp_valid_d    = 1'b0;
        resp_err_d      = 1'b0;
        resp_data_d     = 32'h0000_0000;
        mem_req_valid_d = mem_req_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_be_d        = mem_be_q;
        mem_wdata_d     = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (illegal_f3(req_we, req_funct3) ||
                        (!ALLOW_MISALIGNED && is_split(req_addr[1:0], req_funct3))) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d         = S_REQ0;
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = req_we;
                        mem_addr_d      = req_addr[31:2];
                        mem_be_d        = in_mask_s[3:0];
                        mem_wdata_d     = in_lane_s[31:0];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ0, S_REQ1: begin
                if (mem_req_ready) begin
                    state_d         = (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
                    mem_req_valid_d = 1'b0;
                    mem_we_d        = 1'b0;
                    mem_addr_d      = 30'h0000_0000;
                    mem_be_d        = 4'h0;
                    mem_wdata_d     = 32'h0000_0000;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    lo_d = mem_rdata;
                    if (is_split(addr_q[1:0], f3_q)) begin
                        state_d         = S_REQ1;
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = we_q;
                        mem_addr_d      = addr_q[31:2] + 30'd1;
                        mem_be_d        = cap_mask_s[7:4];
                        mem_wdata_d     = cap_lane_s[63:32];
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = we_q ? 32'h0000_0000
                                            : load_extend(f3_q, addr_q[1:0], 32'h0000_0000, mem_rdata);
                    end
                end else begin
                    state_d = S_WAIT0;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = we_q ? 32'h0000_0000
                                        : load_extend(f3_q, addr_q[1:0], mem_rdata, lo_q);
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // State, captured request and output registers; reset aborts any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            we_q            <= 1'b0;
            f3_q            <= 3'b000;
            addr_q          <= 32'h0000_0000;
            wdata_q         <= 32'h0000_0000;
            lo_q            <= 32'h0000_0000;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_data_q     <= 32'h0000_0000;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 30'h0000_0000;
            mem_be_q        <= 4'h0;
            mem_wdata_q     <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            f3_q            <= f3_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            lo_q            <= lo_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_data_q     <= resp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_be_q        <= mem_be_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_data     = resp_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
